mux_rr_arbiter: RTL
===================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a 4:1 mux datapath. Four requesters
//   compete for the shared mux; the block picks one, drives the mux selects
//   {s1,s0} as sel[1:0], and registers the selected data onto dout with a
//   valid strobe. A hold limit bounds how long one requester keeps the mux.
// PARAMETERS
//   DW        1   data width of each mux input and of dout
//   MAX_HOLD  4   max consecutive GRANT cycles per grant (>=1)
// PORTS
//   clk       in   1      clock, rising-edge
//   rst       in   1      synchronous reset, active-high
//   req       in   4      request, req[i] for input i
//   din       in   4*DW   packed inputs, i0 = din[DW-1:0] ... i3 = din[4*DW-1:3*DW]
//   sel       out  2      mux select {s1,s0} = index of granted input
//   gnt       out  4      one-hot grant, 0 when idle
//   dout      out  DW     registered data of granted input
//   dout_vld  out  1      dout updated this cycle
//   busy      out  1      1 while in GRANT
// BEHAVIOUR
// - Reset (sync, rst=1 at clk edge): state=IDLE, sel=0, gnt=0, dout=0,
//   dout_vld=0, busy=0, ptr=0, hold_cnt=0. Overrides every other event,
//   including mid-GRANT. No transfer completes in the reset cycle.
// - ptr[1:0]: index where the priority search starts. Search order is
//   ptr, ptr+1, ptr+2, ptr+3, mod 4. Winner = first index with req set.
// - hold_cnt width = $clog2(MAX_HOLD+1). Counts GRANT cycles of the current grant.
// - IDLE: if req!=0, register winner: sel=winner, gnt=1<<winner, hold_cnt=1,
//   go to GRANT. Latency: gnt/sel valid the cycle after req first sampled.
//   If req==0, stay IDLE. gnt=0. sel keeps its last value.
// - GRANT, each cycle with g=sel:
//   * Transfer: if req[g]=1, then next cycle dout=din slice g and dout_vld=1.
//     Otherwise dout_vld=0 next cycle and dout holds.
//   * Release when req[g]=0 OR hold_cnt==MAX_HOLD. On release ptr=g+1
//     (3 wraps to 0). Re-search from the new ptr in the same cycle:
//       - winner found: switch directly to it, with no idle bubble.
//         sel/gnt update and hold_cnt=1. The winner may be g again if it is
//         the only requester.
//       - no winner: go to IDLE, gnt=0.
//   * No release: hold_cnt+1, sel/gnt unchanged.
// - Release at the hold limit with req[g]=1 still transfers that cycle's data.
// - A req that drops while its grant is pending gets a GRANT cycle with no
//   transfer, then is released.
// - busy = (state==GRANT). gnt is always one-hot or zero. sel==index of gnt when gnt!=0.
// - dout_vld is a single-cycle strobe per transfer. It is never 1 while rst=1
//   or in the cycle after reset.
// TESTING
// 1. rst=1 for 2 cycles, req=4'b0000 -> gnt=0, sel=0, dout_vld=0, busy=0 stay.
// 2. req=4'b0101, din=4'b0101 held (DW=1) -> gnt=0001 for 4 cycles (sel=00,
//    dout=1, dout_vld=1 one cycle lagged), then gnt=0100 for 4 cycles
//    (sel=10), then alternates.
// 3. req=4'b1111 held, din toggles each cycle -> grant order 0,1,2,3,0, each
//    held 4 cycles. dout equals din[sel] from the previous cycle.
// 4. req=4'b0010 for 2 GRANT cycles, then req=4'b1000 -> after sel=01 drops,
//    the next cycle gnt=1000, sel=11 with no IDLE cycle. dout_vld=0 for one
//    cycle at the switch.
// 5. Single-cycle pulse req=4'b0100 -> gnt=0100 for 1 cycle, dout_vld stays 0,
//    then IDLE.
// 6. rst=1 during the 2nd GRANT cycle of input 2 -> next edge gnt=0, ptr=0.
//    Then req=4'b1010 grants input 1 first, not 3.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux.
// Picks one of four requesters, drives the mux select, and registers the
// selected input onto dout with a single-cycle valid strobe. A hold limit
// caps how many consecutive cycles one requester may keep the mux.
module mux_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [1:0]      sel,
    output logic [3:0]      gnt,
    output logic [DW-1:0]   dout,
    output logic            dout_vld,
    output logic            busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      sel_reg, sel_next;
    logic [1:0]      ptr_reg, ptr_next;
    logic [3:0]      gnt_reg, gnt_next;
    logic [DW-1:0]   dout_reg, dout_next;
    logic            vld_reg, vld_next;
    logic [HW-1:0]   hold_reg, hold_next;

    // Unpacked view of the packed mux inputs
    logic [DW-1:0]   slice [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign slice[gi] = din[gi*DW +: DW];
        end
    endgenerate

    // Priority search: from ptr when idle, from one past the holder when
    // releasing, so the search is ready in the same cycle as a release.
    logic [1:0] start;
    logic [1:0] win;
    logic       found;

    // Rotating first-set search over req starting at 'start'
    always_comb begin
        start = (state_reg == GRANT) ? (sel_reg + 2'd1) : ptr_reg;
        win   = start;
        found = 1'b0;
        // Walk from the farthest offset down so the nearest one wins
        for (int k = 3; k >= 0; k--) begin
            if (req[start + 2'(k)]) begin
                win   = start + 2'(k);
                found = 1'b1;
            end
        end
    end

    // Next-state and datapath decisions for the arbiter FSM
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        dout_next  = dout_reg;
        vld_next   = 1'b0;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                gnt_next  = 4'b0000;
                hold_next = '0;
                if (found) begin
                    state_next = GRANT;
                    sel_next   = win;
                    gnt_next   = 4'b0001 << win;
                    hold_next  = HOLD_ONE;
                end
            end
            GRANT: begin
                // Holder still requesting: move its data this cycle
                if (req[sel_reg]) begin
                    vld_next  = 1'b1;
                    dout_next = slice[sel_reg];
                end
                if (!req[sel_reg] || (hold_reg == HOLD_LIMIT)) begin
                    ptr_next = sel_reg + 2'd1;
                    if (found) begin
                        // Hand over directly, no idle bubble
                        sel_next  = win;
                        gnt_next  = 4'b0001 << win;
                        hold_next = HOLD_ONE;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                        hold_next  = '0;
                    end
                end else begin
                    hold_next = hold_reg + HOLD_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                hold_next  = '0;
            end
        endcase
    end

    // State register; reset wins over any pending grant or transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            gnt_reg   <= 4'b0000;
            dout_reg  <= '0;
            vld_reg   <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            dout_reg  <= dout_next;
            vld_reg   <= vld_next;
            hold_reg  <= hold_next;
        end
    end

    assign sel      = sel_reg;
    assign gnt      = gnt_reg;
    assign dout     = dout_reg;
    assign dout_vld = vld_reg;
    assign busy     = (state_reg == GRANT);

endmodule
